// File: rtl/gray_pkg.sv
// Shared Gray-code definitions: default width and a Gray-to-binary decode
// used by the counter, the downstream converter and the benches.
package gray_pkg;

  localparam int GRAY_W_DEFAULT = 4;
  localparam int GRAY_W_MAX     = 16;

  // Prefix-XOR from the MSB down; zero-padded upper bits decode to zero,
  // so one 16-bit function serves every legal width.
  function automatic logic [GRAY_W_MAX-1:0] gray_to_bin(input logic [GRAY_W_MAX-1:0] g);
    logic [GRAY_W_MAX-1:0] b;
    b[GRAY_W_MAX-1] = g[GRAY_W_MAX-1];
    for (int i = GRAY_W_MAX-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/bin_to_gray.sv
// Combinational binary-to-Gray encoder.
module bin_to_gray #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_counter.sv
// Up/down Gray-code counter with synchronous Gray load and a registered
// terminal-count pulse; G, B and tc all come straight from flops.
module gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_g,
  output logic [WIDTH-1:0] G,
  output logic [WIDTH-1:0] B,
  output logic             tc
);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic             tc_q, tc_d;
  logic             wrap;

  always_comb begin
    bin_d = bin_q;
    tc_d  = 1'b0;
    wrap  = up_dn ? (bin_q == {WIDTH{1'b1}}) : (bin_q == '0);
    if (load) begin
      bin_d = WIDTH'(gray_to_bin(GRAY_W_MAX'(load_g)));
    end else if (en) begin
      bin_d = up_dn ? bin_q + WIDTH'(1) : bin_q - WIDTH'(1);
      tc_d  = wrap;
    end
  end

  // Encode the next binary value so G is registered alongside B.
  bin_to_gray #(.WIDTH(WIDTH)) u_b2g (
    .bin  (bin_d),
    .gray (g_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q <= '0;
      g_q   <= '0;
      tc_q  <= 1'b0;
    end else begin
      bin_q <= bin_d;
      g_q   <= g_d;
      tc_q  <= tc_d;
    end
  end

  assign G  = g_q;
  assign B  = bin_q;
  assign tc = tc_q;

endmodule

// File: tb/tb_gray_counter.sv
// Directed bench for gray_counter at WIDTH=4 with a small reference model
// for the free-running section.
module tb_gray_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         up_dn = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_g = '0;
  logic [W-1:0] G, B;
  logic         tc;

  int nvec = 0;
  int nmis = 0;

  gray_counter #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .up_dn  (up_dn),
    .load   (load),
    .load_g (load_g),
    .G      (G),
    .B      (B),
    .tc     (tc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk3(input string tag, input logic [W-1:0] eg, input logic [W-1:0] eb,
                      input logic etc);
    chk({tag, "_G"}, 32'(G), 32'(eg));
    chk({tag, "_B"}, 32'(B), 32'(eb));
    chk({tag, "_tc"}, 32'(tc), 32'(etc));
  endtask

  logic [W-1:0] exp_b, exp_g, prev_g;
  int           tc_cnt;

  initial begin
    // Power-on reset is asynchronous: outputs are zero before any edge.
    #2;
    chk3("por", 4'b0000, 4'b0000, 1'b0);
    step();
    rst = 1'b0;

    // Count up through the wrap so a tc pulse is pending, then reset mid-cycle.
    en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 16; i++) step();
    chk3("wrap_pre_rst", 4'b0000, 4'b0000, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk3("rst_async", 4'b0000, 4'b0000, 1'b0);
    load = 1'b1; load_g = 4'b1010;
    step();
    chk3("rst_hold", 4'b0000, 4'b0000, 1'b0);
    load = 1'b0;
    rst = 1'b0;
    step(); chk3("up1", 4'b0001, 4'b0001, 1'b0);
    step(); chk3("up2", 4'b0011, 4'b0010, 1'b0);
    step(); chk3("up3", 4'b0010, 4'b0011, 1'b0);

    // Load max value then wrap up.
    en = 1'b0; load = 1'b1; load_g = 4'b1000;
    step(); chk3("ld_1000", 4'b1000, 4'b1111, 1'b0);
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    step(); chk3("up_wrap", 4'b0000, 4'b0000, 1'b1);
    en = 1'b0;
    step(); chk3("tc_once", 4'b0000, 4'b0000, 1'b0);

    // Down wrap, then one more down step, then an immediate direction change.
    en = 1'b1; up_dn = 1'b0;
    step(); chk3("dn_wrap", 4'b1000, 4'b1111, 1'b1);
    step(); chk3("dn_next", 4'b1001, 4'b1110, 1'b0);
    up_dn = 1'b1;
    step(); chk3("dir_chg", 4'b1000, 4'b1111, 1'b0);

    // Load beats enable; loading a wrap value never raises tc.
    load = 1'b1; load_g = 4'b1011;
    step(); chk3("ld_pri", 4'b1011, 4'b1101, 1'b0);
    load_g = 4'b0000;
    step(); chk3("ld_zero", 4'b0000, 4'b0000, 1'b0);
    up_dn = 1'b0; load_g = 4'b1000;
    step(); chk3("ld_max_dn", 4'b1000, 4'b1111, 1'b0);

    // Hold for 5 cycles at G=1001.
    load_g = 4'b1001;
    step(); chk3("ld_1001", 4'b1001, 4'b1110, 1'b0);
    load = 1'b0; en = 1'b0; up_dn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(); chk3("hold", 4'b1001, 4'b1110, 1'b0);
    end

    // Free-run: 40 cycles up then 40 down with en gaps (35 up + 36 down
    // enabled steps from zero -> 2 + 3 wraps).
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    exp_b = '0; prev_g = '0; tc_cnt = 0;
    for (int i = 0; i < 80; i++) begin
      up_dn = (i < 40);
      en    = (i < 40) ? (i % 8 != 3) : ((i - 40) % 10 != 7);
      step();
      if (en) exp_b = up_dn ? exp_b + 4'd1 : exp_b - 4'd1;
      exp_g = exp_b ^ (exp_b >> 1);
      chk("fr_B", 32'(B), 32'(exp_b));
      chk("fr_G", 32'(G), 32'(exp_g));
      if (en) chk("fr_1bit", 32'($countones(G ^ prev_g)), 32'd1);
      if (tc) tc_cnt++;
      prev_g = G;
    end
    chk("fr_tc_count", 32'(tc_cnt), 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
